alu_responder: RTL and testbench

Handshaked, registered responder for the N-bit ALU opcode set (00 add, 01 or, 10 sub, 11 xor). The block accepts operand/opcode requests over a valid/ready interface and computes each result in one cycle. Results and flags go into a small result FIFO, which the requester drains through a second valid/ready interface. The block is the responder end of the ALU request stream: bus masters and bench drivers issue requests, and this block answers them in order.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_result_fifo.sv | 80 ++++++++
 rtl/alu_responder.sv | 91 +++++++++
 tb/tb_alu_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU responder: opcodes, result-entry layout and
// occupancy state encodings.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // A result entry is packed as {carry, zero, result[N-1:0]}.
  function automatic int entry_w(input int n);
    return n + 2;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous result FIFO; full/empty come from an occupancy state machine.
//   state       | meaning
//   OCC_EMPTY   | no entries queued
//   OCC_PARTIAL | some entries queued, room for more
//   OCC_FULL    | DEPTH entries queued, pushes refused
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  occ_state_e    state_q, state_d;
  logic          push_ok, pop_ok;

  assign full    = (state_q == OCC_FULL);
  assign empty   = (state_q == OCC_EMPTY);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (count_d == '0) begin
      state_d = OCC_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = OCC_FULL;
    end else begin
      state_d = OCC_PARTIAL;
    end
  end

  // Storage is cleared on reset so the head reads as all-zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OCC_EMPTY;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_responder.sv
// Handshaked ALU responder: computes add/or/sub/xor per request and queues
// {carry, zero, result} for in-order draining; counts completed responses.
module alu_responder
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic [1:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             carry,
  output logic             zero,
  output logic [CNT_W-1:0] resp_count
);

  localparam int EW = entry_w(N);

  logic [N:0]       sum_w, diff_w;
  logic [N-1:0]     res_w;
  logic             carry_w;
  logic [EW-1:0]    wdata_w, head_w;
  logic             full_w, empty_w, push_w, pop_w;
  logic [CNT_W-1:0] resp_count_q, resp_count_d;

  // The top bit of the widened difference is the unsigned borrow (A < B).
  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = {1'b0, A} - {1'b0, B};

  always_comb begin
    res_w   = '0;
    carry_w = 1'b0;
    case (OP)
      OP_ADD:  {carry_w, res_w} = sum_w;
      OP_SUB:  {carry_w, res_w} = diff_w;
      OP_OR:   res_w = A | B;
      default: res_w = A ^ B;
    endcase
  end

  assign wdata_w = {carry_w, (res_w == '0), res_w};

  assign in_ready  = !full_w;
  assign out_valid = !empty_w;
  assign push_w    = in_valid && in_ready;
  assign pop_w     = out_valid && out_ready;

  alu_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_w),
    .pop   (pop_w),
    .wdata (wdata_w),
    .rdata (head_w),
    .full  (full_w),
    .empty (empty_w)
  );

  assign result = head_w[N-1:0];
  assign zero   = head_w[N];
  assign carry  = head_w[N+1];

  always_comb begin
    resp_count_d = resp_count_q;
    if (pop_w) begin
      resp_count_d = resp_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_count_q <= '0;
    end else begin
      resp_count_q <= resp_count_d;
    end
  end

  assign resp_count = resp_count_q;

endmodule

// File: tb/tb_alu_responder.sv
// Directed plus randomized bench for alu_responder against a queue-based model.
module tb_alu_responder;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic [1:0]       OP;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             carry;
  logic             zero;
  logic [CNT_W-1:0] resp_count;

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;
  logic [5:0] q[$];

  alu_responder #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .OP         (OP),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .zero       (zero),
    .resp_count (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected entry {carry, zero, result} from plain integer arithmetic.
  function automatic logic [5:0] model(input int a, input int b, input int op);
    int r;
    bit c;
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 15); r = r % 16; end
      1: begin r = a | b; end
      2: begin c = (a < b); r = (a - b + 16) % 16; end
      default: begin r = a ^ b; end
    endcase
    return {c, (r == 0), 4'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit acc, pp;
    logic [5:0] e;
    acc = in_valid && (q.size() < DEPTH) && !rst;
    pp  = out_ready && (q.size() > 0) && !rst;
    e   = model(int'(A), int'(B), int'(OP));
    @(posedge clk);
    if (rst) begin
      q.delete();
      pops = 0;
    end else begin
      if (pp) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic check_all();
    logic [5:0] h;
    chk("in_ready", in_ready, (q.size() < DEPTH));
    chk("out_valid", out_valid, (q.size() != 0));
    chk("resp_count", resp_count, pops % 16);
    if (q.size() > 0) begin
      h = q[0];
      chk("result", result, h[3:0]);
      chk("zero", zero, h[4]);
      chk("carry", carry, h[5]);
    end
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    in_valid = 1'b1;
    A = a;
    B = b;
    OP = op;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 4'(  $urandom); B = 4'($urandom); OP = 2'($urandom);

    // reset values
    cycle(); cycle();
    check_all();
    chk("rst_result", result, 4'h0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    rst = 1'b0;
    cycle();
    check_all();
    chk("idle_result", result, 4'h0);

    // add with carry
    req(4'hF, 4'h1, 2'b00);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_all();
    chk("add_result", result, 4'h0);
    chk("add_carry", carry, 1'b1);
    chk("add_zero", zero, 1'b1);
    cycle();
    check_all();
    chk("add_count", resp_count, 4'd1);

    // sub borrow, xor, then a third request held until space frees
    out_ready = 1'b0;
    req(4'h3, 4'h5, 2'b10); cycle(); check_all();
    req(4'hA, 4'h5, 2'b11); cycle(); check_all();
    chk("full_ready", in_ready, 1'b0);
    req(4'h7, 4'h9, 2'b00); cycle(); check_all();
    chk("sub_result", result, 4'hE);
    chk("sub_carry", carry, 1'b1);
    out_ready = 1'b1;
    cycle(); check_all();
    chk("xor_result", result, 4'hF);
    chk("xor_carry", carry, 1'b0);
    chk("xor_zero", zero, 1'b0);
    cycle(); check_all();
    in_valid = 1'b0;
    chk("third_result", result, 4'h0);
    chk("third_carry", carry, 1'b1);
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      cycle(); check_all();
    end
    chk("drained", out_valid, 1'b0);

    // streaming OR requests with simultaneous accept and pop
    for (int i = 0; i < 8; i++) begin
      req(4'($urandom), 4'($urandom), 2'b01);
      cycle(); check_all();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      cycle(); check_all();
    end
    chk("stream_count", resp_count, 4'd12);

    // backpressure stability
    out_ready = 1'b0;
    req(4'h2, 4'h9, 2'b10); cycle();
    in_valid = 1'b0; A = 4'($urandom); B = 4'($urandom); OP = 2'($urandom);
    for (int i = 0; i < 5; i++) begin
      cycle(); check_all();
      chk("hold_result", result, 4'h9);
      chk("hold_carry", carry, 1'b1);
    end

    // counter wrap
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !(pops >= 16 && (pops % 16) == 1); i++) begin
      req(4'($urandom), 4'($urandom), 2'($urandom));
      cycle(); check_all();
    end
    chk("cnt_wrap", resp_count, 4'd1);

    // reset mid-operation with a request pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(4'($urandom), 4'($urandom), 2'($urandom));
      cycle();
    end
    check_all();
    rst = 1'b1;
    req(4'h1, 4'h1, 2'b00);
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check_all();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_count", resp_count, 4'd0);
    cycle();
    chk("mid_rst_noq", out_valid, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      A = 4'($urandom); B = 4'($urandom); OP = 2'($urandom);
      cycle();
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
